mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 31 +++
 rtl/mult_arbiter_pipe.sv | 23 ++
 rtl/mult_arbiter.sv | 139 +++++++++++++
 tb/tb_mult_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants, FSM state and tag types for the shared-multiplier arbiter.
// Optional build macro MULT_ARB_PRIO0_EN gives requester 0 strict priority.
package mult_arb_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 15;
   localparam int DEF_LAT  = 3;
   localparam int IDX_W    = 3;   // wide enough for up to 8 requesters

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   // (base + off) mod n, valid while base < n and off < n
   function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base,
                                                input int unsigned      off,
                                                input int unsigned      n);
      logic [IDX_W:0] s;
      s = {1'b0, base} + (IDX_W+1)'(off);
      if (s >= (IDX_W+1)'(n)) s = s - (IDX_W+1)'(n);
      return s[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/mult_arbiter_pipe.sv
// LAT-stage registered unsigned W x W multiplier; en gates operand capture only,
// the later stages always advance so latency stays fixed.
module mult_pipe #(
   parameter int W   = 15,
   parameter int LAT = 3
) (
   input  logic           clk,
   input  logic           en,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   logic [2*W-1:0] stg [LAT];

   always_ff @(posedge clk) begin
      if (en) stg[0] <= (2*W)'(a) * (2*W)'(b);
      for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
   end

   assign p = stg[LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
// Define MULT_ARB_PRIO0_EN to give requester 0 strict priority over the rest.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W,
   parameter int LAT  = DEF_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic              flush,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*W-1:0]    rsp_data,
   output logic              busy
);

   localparam int CW = $clog2(LAT + 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, gnt_idx;
   logic             gnt_found, accept_en, xfer, retire, ptr_upd;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [NREQ-1:0]  rot, rsp_valid_nxt;
   logic [W-1:0]     a_sel, b_sel;
   logic [2*W-1:0]   prod;
   tag_t             tag_q [LAT];

   // rotate so bit 0 is the requester at the pointer, then take the first set bit
   always_comb begin
      rot       = NREQ'({req_valid, req_valid} >> ptr);
      gnt_found = 1'b0;
      gnt_idx   = '0;
`ifdef MULT_ARB_PRIO0_EN
      if (req_valid[0]) gnt_found = 1'b1;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && rot[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = rr_wrap(ptr, k, NREQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      a_sel     = '0;
      b_sel     = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_idx == IDX_W'(k)) begin
            req_ready[k] = accept_en && gnt_found;
            a_sel        = req_a[k*W +: W];
            b_sel        = req_b[k*W +: W];
         end
      end
   end

   assign xfer   = accept_en && gnt_found;
   assign retire = tag_q[LAT-1].valid;

`ifdef MULT_ARB_PRIO0_EN
   assign ptr_upd = xfer && (gnt_idx != '0);
`else
   assign ptr_upd = xfer;
`endif

   always_comb begin
      cnt_nxt = cnt;
      if (xfer && !retire)      cnt_nxt = cnt + 1'b1;
      else if (!xfer && retire) cnt_nxt = cnt - 1'b1;
   end

   always_comb begin
      rsp_valid_nxt = '0;
      for (int k = 0; k < NREQ; k++)
         rsp_valid_nxt[k] = retire && (tag_q[LAT-1].idx == IDX_W'(k));
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state; leaving BUSY/DRAIN waits for the registered count to hit zero
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush && cnt_nxt != '0) state_nxt = DRAIN;
            else if (xfer)              state_nxt = BUSY;
         end
         BUSY: begin
            if (flush && cnt_nxt != '0)    state_nxt = DRAIN;
            else if (cnt == '0 && !xfer)   state_nxt = IDLE;
         end
         DRAIN: begin
            if (cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy      = (state != IDLE);
      accept_en = (state != DRAIN) && !flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         cnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         if (ptr_upd) ptr <= rr_wrap(gnt_idx, 1, NREQ);
         cnt       <= cnt_nxt;
         tag_q[0]  <= tag_t'{valid: xfer, idx: gnt_idx};
         for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= retire ? prod : '0;
      end
   end

   mult_pipe #(.W(W), .LAT(LAT)) u_mult (
      .clk (clk),
      .en  (xfer),
      .a   (a_sel),
      .b   (b_sel),
      .p   (prod)
   );

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: expected grants checked per step, expected
// responses queued at grant time and matched (order, data, cycle) on output.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 15;
   localparam int LAT  = 3;
`ifdef MULT_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   typedef struct {
      logic [3:0]  oh;
      logic [29:0] data;
      int          due;
   } sb_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              flush;
   logic [NREQ-1:0]   rsp_valid;
   logic [2*W-1:0]    rsp_data;
   logic              busy;

   int          n_pass = 0;
   int          n_chk  = 0;
   int          cyc    = 0;
   sb_t         q[$];
   logic        fix_en = 1'b0;
   logic [14:0] fix_a, fix_b;
   logic [14:0] a_l [4];
   logic [14:0] b_l [4];

   mult_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // one cycle of stimulus; the grant lands on the next rising edge
   task automatic step(input logic [3:0] vld, input logic [3:0] exp_rdy, input logic flsh);
      @(negedge clk);
      req_valid = vld;
      flush     = flsh;
      for (int i = 0; i < 4; i++) begin
         a_l[i] = fix_en ? fix_a : 15'($urandom_range(0, 32767));
         b_l[i] = fix_en ? fix_b : 15'($urandom_range(0, 32767));
      end
      req_a = {a_l[3], a_l[2], a_l[1], a_l[0]};
      req_b = {b_l[3], b_l[2], b_l[1], b_l[0]};
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < 4; i++)
         if (exp_rdy[i])
            q.push_back('{oh: 4'(1 << i),
                          data: {15'd0, a_l[i]} * {15'd0, b_l[i]},
                          due: cyc + 1 + LAT});
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         if (rsp_valid != '0) begin
            if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            else begin
               e = q.pop_front();
               chk("rsp_valid", 32'(rsp_valid), 32'(e.oh));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               chk("rsp_cycle", cyc, e.due);
            end
         end else chk("rsp_data_idle", 32'(rsp_data), 32'd0);
      end
   end

   initial begin
      rst = 1'b1; req_valid = '0; flush = 1'b0; req_a = '0; req_b = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);

      // single request, known product, busy falls one cycle after the response
      fix_en = 1'b1; fix_a = 15'h78AB; fix_b = 15'h3200;
      step(4'b0001, 4'b0001, 1'b0);
      fix_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step(4'b0000, 4'b0000, 1'b0);
         chk("busy_single", 32'(busy), 32'(k <= 4));
      end

      // park pointer at 0, then all four requesting back-to-back
      step(4'b1000, 4'b1000, 1'b0);
      for (int k = 0; k < 8; k++)
         step(4'b1111, PRIO0 ? 4'b0001 : 4'(1 << (k % 4)), 1'b0);
      repeat (6) step(4'b0000, 4'b0000, 1'b0);

      // largest operands
      fix_en = 1'b1; fix_a = 15'h7FFF; fix_b = 15'h7FFF;
      step(4'b0001, 4'b0001, 1'b0);
      fix_en = 1'b0;
      repeat (6) step(4'b0000, 4'b0000, 1'b0);

      // flush with two in flight; dropping flush must not end the drain early
      step(4'b0010, 4'b0010, 1'b0);
      step(4'b0100, 4'b0100, 1'b0);
      step(4'b0010, 4'b0000, 1'b1);
      chk("busy_flush", 32'(busy), 32'd1);
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0000, 1'b0);
      step(4'b0010, 4'b0000, 1'b0);
      chk("busy_drain_last", 32'(busy), 32'd1);
      step(4'b0000, 4'b0000, 1'b0);
      chk("busy_after_drain", 32'(busy), 32'd0);

      // reset with three in flight discards them all
      step(4'b1111, PRIO0 ? 4'b0001 : 4'b1000, 1'b0);
      step(4'b1111, PRIO0 ? 4'b0001 : 4'b0001, 1'b0);
      step(4'b1111, PRIO0 ? 4'b0001 : 4'b0010, 1'b0);
      @(negedge clk);
      rst = 1'b1; req_valid = '0;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
      repeat (5) step(4'b0000, 4'b0000, 1'b0);
      chk("midrst_idle_busy", 32'(busy), 32'd0);
      step(4'b1111, 4'b0001, 1'b0);
      repeat (6) step(4'b0000, 4'b0000, 1'b0);

      // req0 and req2 contending
      step(4'b1000, 4'b1000, 1'b0);
      for (int k = 0; k < 4; k++)
         step(4'b0101, PRIO0 ? 4'b0001 : ((k % 2 == 0) ? 4'b0001 : 4'b0100), 1'b0);

      for (int k = 0; k < 20 && q.size() != 0; k++) step(4'b0000, 4'b0000, 1'b0);
      chk("queue_drained", q.size(), 32'd0);
      step(4'b0000, 4'b0000, 1'b0);
      step(4'b0000, 4'b0000, 1'b0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
